obi2ahbm_bridge: RTL and testbench

OBI2AHBM_BRIDGE -- requirements
Module: obi2ahbm_bridge

---
 rtl/obi2ahbm_bridge.sv | 160 ++++++++++++++++
 tb/tb_obi2ahbm_bridge.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi2ahbm_bridge.sv
// OBI-to-AHB-Lite master bridge: single transfers, at most one outstanding data phase,
// byte-enable to hsize/haddr translation and saturating transfer/error statistics.
module obi2ahbm_bridge #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned LOCAL_BE_ERR = 1
) (
  input  logic                hclk_i,
  input  logic                hreset_i,
  output logic [ADDR_W-1:0]   haddr_o,
  output logic [2:0]          hburst_o,
  output logic                hmastlock_o,
  output logic [3:0]          hprot_o,
  output logic [2:0]          hsize_o,
  output logic [1:0]          htrans_o,
  output logic [DATA_W-1:0]   hwdata_o,
  output logic                hwrite_o,
  input  logic [DATA_W-1:0]   hrdata_i,
  input  logic                hready_i,
  input  logic                hresp_i,
  input  logic                data_req_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  input  logic                data_we_i,
  input  logic [DATA_W/8-1:0] data_be_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                data_err_o,
  input  logic                pending_dbus_xfer_i,
  input  logic                priv_mode_i,
  output logic [CNT_W-1:0]    xfer_cnt_o,
  output logic [CNT_W-1:0]    err_cnt_o
);

  localparam int unsigned       NB            = DATA_W / 8;
  localparam int unsigned       LB            = $clog2(NB);
  localparam logic [1:0]        HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]        HTRANS_NONSEQ = 2'b10;
  localparam logic [ADDR_W-1:0] LANE_MASK     = ADDR_W'(NB - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX       = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_LERR} state_e;

  state_e            state_q, state_d;
  logic              be_legal;
  logic [2:0]        be_size;
  logic [LB-1:0]     be_lo;
  logic              gnt_c, ahb_gnt_c, lerr_gnt_c;
  logic [ADDR_W-1:0] req_addr_c;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        size_q;
  logic              write_q;
  logic [3:0]        prot_q;

  assign hburst_o     = 3'b000;
  assign hmastlock_o  = 1'b0;
  assign data_rdata_o = hrdata_i;

  // Match byte enables against every naturally aligned power-of-two lane group;
  // anything unmatched falls back to full-width, lane-aligned.
  always_comb begin
    be_legal = 1'b0;
    be_size  = 3'(LB);
    be_lo    = '0;
    for (int unsigned s = 0; s <= LB; s++) begin
      for (int unsigned o = 0; o < NB; o += (32'd1 << s)) begin
        if (data_be_i == NB'(((32'd1 << (32'd1 << s)) - 32'd1) << o)) begin
          be_legal = 1'b1;
          be_size  = 3'(s);
          be_lo    = LB'(o);
        end
      end
    end
  end

  assign req_addr_c = (data_addr_i & ~LANE_MASK) | ADDR_W'(be_lo);

  always_ff @(posedge hclk_i) begin
    if (hreset_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Grant, address phase, response and next-state logic.
  always_comb begin
    state_d       = state_q;
    gnt_c         = 1'b0;
    ahb_gnt_c     = 1'b0;
    lerr_gnt_c    = 1'b0;
    data_gnt_o    = 1'b0;
    data_rvalid_o = 1'b0;
    data_err_o    = 1'b0;
    htrans_o      = HTRANS_IDLE;
    haddr_o       = addr_q;
    hsize_o       = size_q;
    hwrite_o      = write_q;
    hprot_o       = prot_q;
    if (!hreset_i) begin
      gnt_c      = data_req_i & hready_i & !hresp_i & !pending_dbus_xfer_i & (state_q != S_LERR);
      ahb_gnt_c  = gnt_c & (be_legal | (LOCAL_BE_ERR == 0));
      lerr_gnt_c = gnt_c & !ahb_gnt_c;
      data_gnt_o = gnt_c;
      if (ahb_gnt_c) begin
        htrans_o = HTRANS_NONSEQ;
        haddr_o  = req_addr_c;
        hsize_o  = be_size;
        hwrite_o = data_we_i;
        hprot_o  = {2'b00, priv_mode_i, 1'b1};
      end
      case (state_q)
        S_IDLE: begin
          if (ahb_gnt_c)       state_d = S_DATA;
          else if (lerr_gnt_c) state_d = S_LERR;
        end
        S_DATA: begin
          data_rvalid_o = hready_i;
          data_err_o    = hresp_i;
          if (hready_i) begin
            if (ahb_gnt_c)       state_d = S_DATA;
            else if (lerr_gnt_c) state_d = S_LERR;
            else                 state_d = S_IDLE;
          end
        end
        S_LERR: begin
          data_rvalid_o = 1'b1;
          data_err_o    = 1'b1;
          state_d       = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Held address-phase attributes, write data and statistics.
  always_ff @(posedge hclk_i) begin
    if (hreset_i) begin
      addr_q     <= '0;
      size_q     <= '0;
      write_q    <= 1'b0;
      prot_q     <= '0;
      hwdata_o   <= '0;
      xfer_cnt_o <= '0;
      err_cnt_o  <= '0;
    end else begin
      if (ahb_gnt_c) begin
        addr_q  <= req_addr_c;
        size_q  <= be_size;
        write_q <= data_we_i;
        prot_q  <= {2'b00, priv_mode_i, 1'b1};
      end
      if (gnt_c && data_we_i) hwdata_o <= data_wdata_i;
      if ((state_q == S_DATA) && hready_i && (xfer_cnt_o != CNT_MAX))
        xfer_cnt_o <= xfer_cnt_o + CNT_W'(1);
      if (data_rvalid_o && data_err_o && (err_cnt_o != CNT_MAX))
        err_cnt_o <= err_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_obi2ahbm_bridge.sv
// Bench for obi2ahbm_bridge: two instances (default, and CNT_W=2 with LOCAL_BE_ERR=0)
// checked every cycle against a transaction-level model, plus directed literal checks.
module tb_obi2ahbm_bridge;

  logic        clk = 1'b0;
  logic        rst, req, we, hready, hresp, pend, priv;
  logic [3:0]  be;
  logic [31:0] addr, wdata, hrdata;

  logic [31:0] haddr_a, hwdata_a, rdata_a, haddr_b, hwdata_b, rdata_b;
  logic [2:0]  hburst_a, hsize_a, hburst_b, hsize_b;
  logic [3:0]  hprot_a, hprot_b;
  logic [1:0]  htrans_a, htrans_b;
  logic        hmlock_a, hwrite_a, gnt_a, rvalid_a, err_a;
  logic        hmlock_b, hwrite_b, gnt_b, rvalid_b, err_b;
  logic [15:0] xc_a, ec_a;
  logic [1:0]  xc_b, ec_b;

  int n_chk  = 0;
  int n_fail = 0;
  bit model_en = 1'b0;

  always #5 clk = ~clk;

  obi2ahbm_bridge u_a (
    .hclk_i(clk), .hreset_i(rst), .haddr_o(haddr_a), .hburst_o(hburst_a),
    .hmastlock_o(hmlock_a), .hprot_o(hprot_a), .hsize_o(hsize_a), .htrans_o(htrans_a),
    .hwdata_o(hwdata_a), .hwrite_o(hwrite_a), .hrdata_i(hrdata), .hready_i(hready),
    .hresp_i(hresp), .data_req_i(req), .data_gnt_o(gnt_a), .data_rvalid_o(rvalid_a),
    .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_rdata_o(rdata_a), .data_err_o(err_a), .pending_dbus_xfer_i(pend),
    .priv_mode_i(priv), .xfer_cnt_o(xc_a), .err_cnt_o(ec_a)
  );

  obi2ahbm_bridge #(.CNT_W(2), .LOCAL_BE_ERR(0)) u_b (
    .hclk_i(clk), .hreset_i(rst), .haddr_o(haddr_b), .hburst_o(hburst_b),
    .hmastlock_o(hmlock_b), .hprot_o(hprot_b), .hsize_o(hsize_b), .htrans_o(htrans_b),
    .hwdata_o(hwdata_b), .hwrite_o(hwrite_b), .hrdata_i(hrdata), .hready_i(hready),
    .hresp_i(hresp), .data_req_i(req), .data_gnt_o(gnt_b), .data_rvalid_o(rvalid_b),
    .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_rdata_o(rdata_b), .data_err_o(err_b), .pending_dbus_xfer_i(pend),
    .priv_mode_i(priv), .xfer_cnt_o(xc_b), .err_cnt_o(ec_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state per instance: data phase outstanding, local error owed, registers.
  bit          m_busy [2];
  bit          m_lerr [2];
  logic [31:0] m_hwd  [2];
  int          m_xc   [2];
  int          m_ec   [2];
  int          cmax   [2] = '{65535, 3};
  bit          lbe    [2] = '{1'b1, 1'b0};

  // Legal = 1, 2 or 4 contiguous enabled bytes starting at a multiple of their count.
  function automatic void be_info(input logic [3:0] b, output bit ok, output int sz, output int lo);
    int n = 0;
    int first = -1;
    for (int i = 0; i < 4; i++)
      if (b[i]) begin
        n++;
        if (first < 0) first = i;
      end
    ok = 0; sz = 2; lo = 0;
    if ((n == 1 || n == 2 || n == 4) && (first % n == 0) && (b == 4'(((1 << n) - 1) << first))) begin
      ok = 1;
      sz = (n == 1) ? 0 : (n == 2) ? 1 : 2;
      lo = first;
    end
  endfunction

  task automatic mcheck(input int k, input logic gnt, input logic [1:0] htr, input logic [31:0] ha,
                        input logic [2:0] hs, input logic hw, input logic [3:0] hp,
                        input logic [31:0] hwd, input logic rv, input logic [31:0] rd,
                        input logic er, input logic [15:0] xc, input logic [15:0] ec);
    bit ok, g, iss, le, e_rv, e_er;
    int sz, lo;
    be_info(be, ok, sz, lo);
    g    = !rst && req && hready && !hresp && !pend && !m_lerr[k];
    iss  = g && (ok || !lbe[k]);
    le   = g && !iss;
    e_rv = !rst && ((m_busy[k] && hready) || m_lerr[k]);
    e_er = m_lerr[k] || hresp;
    chk($sformatf("m%0d_gnt", k), 64'(gnt), 64'(g));
    chk($sformatf("m%0d_htrans", k), 64'(htr), iss ? 64'h2 : 64'h0);
    if (iss) begin
      chk($sformatf("m%0d_haddr", k), 64'(ha), 64'((addr & 32'hFFFF_FFFC) | 32'(ok ? lo : 0)));
      chk($sformatf("m%0d_hsize", k), 64'(hs), 64'(ok ? sz : 2));
      chk($sformatf("m%0d_hwrite", k), 64'(hw), 64'(we));
      chk($sformatf("m%0d_hprot", k), 64'(hp), 64'({2'b00, priv, 1'b1}));
    end
    chk($sformatf("m%0d_rvalid", k), 64'(rv), 64'(e_rv));
    if (e_rv) begin
      chk($sformatf("m%0d_err", k), 64'(er), 64'(e_er));
      chk($sformatf("m%0d_rdata", k), 64'(rd), 64'(hrdata));
    end
    chk($sformatf("m%0d_hwdata", k), 64'(hwd), 64'(m_hwd[k]));
    chk($sformatf("m%0d_xfer_cnt", k), 64'(xc), 64'(m_xc[k]));
    chk($sformatf("m%0d_err_cnt", k), 64'(ec), 64'(m_ec[k]));
    if (rst) begin
      m_busy[k] = 0; m_lerr[k] = 0; m_hwd[k] = '0; m_xc[k] = 0; m_ec[k] = 0;
    end else begin
      if (g && we) m_hwd[k] = wdata;
      if (m_busy[k] && hready && m_xc[k] < cmax[k]) m_xc[k]++;
      if (e_rv && e_er && m_ec[k] < cmax[k]) m_ec[k]++;
      m_busy[k] = iss || (m_busy[k] && !hready);
      m_lerr[k] = le;
    end
  endtask

  always @(negedge clk) begin
    if (model_en) begin
      mcheck(0, gnt_a, htrans_a, haddr_a, hsize_a, hwrite_a, hprot_a, hwdata_a,
             rvalid_a, rdata_a, err_a, xc_a, ec_a);
      mcheck(1, gnt_b, htrans_b, haddr_b, hsize_b, hwrite_b, hprot_b, hwdata_b,
             rvalid_b, rdata_b, err_b, 16'(xc_b), 16'(ec_b));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_in();
    req = 0; we = 0; be = 4'hF; hresp = 0; hready = 1; pend = 0;
  endtask

  task automatic set_req(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
    req = 1; we = w; be = b; addr = a; wdata = d;
  endtask

  initial begin
    rst = 1; idle_in(); req = 1; priv = 1; addr = 32'h0; wdata = 32'h0; hrdata = 32'h0;
    tick();
    model_en = 1'b1;

    // Reset state
    settle();
    chk("rst_gnt", 64'(gnt_a), 64'h0);
    chk("rst_rvalid", 64'(rvalid_a), 64'h0);
    chk("rst_htrans", 64'(htrans_a), 64'h0);
    chk("rst_hwdata", 64'(hwdata_a), 64'h0);
    chk("rst_xfer_cnt", 64'(xc_a), 64'h0);
    tick();

    // Word read, zero wait states
    rst = 0; set_req(0, 4'hF, 32'h100, 32'h0);
    settle();
    chk("rd_gnt", 64'(gnt_a), 64'h1);
    chk("rd_htrans", 64'(htrans_a), 64'h2);
    chk("rd_hsize", 64'(hsize_a), 64'h2);
    chk("rd_haddr", 64'(haddr_a), 64'h100);
    chk("rd_hprot", 64'(hprot_a), 64'h3);
    tick();
    idle_in(); hrdata = 32'hDEAD_BEEF;
    settle();
    chk("rd_rvalid", 64'(rvalid_a), 64'h1);
    chk("rd_rdata", 64'(rdata_a), 64'hDEAD_BEEF);
    chk("rd_err", 64'(err_a), 64'h0);
    tick();
    settle();
    chk("rd_xfer_cnt", 64'(xc_a), 64'h1);
    chk("rd_rvalid_after", 64'(rvalid_a), 64'h0);
    tick();

    // Byte write: lane 2 of word 0x200
    priv = 0; set_req(1, 4'b0100, 32'h203, 32'h00AA_0000);
    settle();
    chk("bw_haddr", 64'(haddr_a), 64'h202);
    chk("bw_hsize", 64'(hsize_a), 64'h0);
    chk("bw_hwrite", 64'(hwrite_a), 64'h1);
    chk("bw_hprot", 64'(hprot_a), 64'h1);
    tick();
    idle_in();
    settle();
    chk("bw_hwdata", 64'(hwdata_a), 64'h00AA_0000);
    chk("bw_rvalid", 64'(rvalid_a), 64'h1);
    tick();

    // Write with 2 wait states, read request waiting behind it
    priv = 1; set_req(1, 4'hF, 32'h300, 32'h1122_3344);
    settle();
    chk("ww_htrans", 64'(htrans_a), 64'h2);
    tick();
    for (int w = 0; w < 2; w++) begin
      set_req(0, 4'hF, 32'h304, 32'hFFFF_FFFF); hready = 0;
      settle();
      chk("ww_wait_gnt", 64'(gnt_a), 64'h0);
      chk("ww_wait_htrans", 64'(htrans_a), 64'h0);
      chk("ww_wait_hwdata", 64'(hwdata_a), 64'h1122_3344);
      chk("ww_wait_haddr", 64'(haddr_a), 64'h300);
      chk("ww_wait_hwrite", 64'(hwrite_a), 64'h1);
      chk("ww_wait_rvalid", 64'(rvalid_a), 64'h0);
      tick();
    end
    hready = 1;
    settle();
    chk("ww_done_rvalid", 64'(rvalid_a), 64'h1);
    chk("ww_done_hwdata", 64'(hwdata_a), 64'h1122_3344);
    chk("ww_rd_gnt", 64'(gnt_a), 64'h1);
    chk("ww_rd_htrans", 64'(htrans_a), 64'h2);
    chk("ww_rd_haddr", 64'(haddr_a), 64'h304);
    tick();
    idle_in(); hrdata = 32'hCAFE_F00D;
    settle();
    chk("ww_rd_rvalid", 64'(rvalid_a), 64'h1);
    chk("ww_rd_rdata", 64'(rdata_a), 64'hCAFE_F00D);
    tick();

    // Two-cycle AHB error with a request waiting
    set_req(0, 4'hF, 32'h400, 32'h0);
    tick();
    hresp = 1; hready = 0;
    settle();
    chk("err1_gnt", 64'(gnt_a), 64'h0);
    chk("err1_htrans", 64'(htrans_a), 64'h0);
    chk("err1_rvalid", 64'(rvalid_a), 64'h0);
    tick();
    hready = 1;
    settle();
    chk("err2_rvalid", 64'(rvalid_a), 64'h1);
    chk("err2_err", 64'(err_a), 64'h1);
    chk("err2_gnt", 64'(gnt_a), 64'h0);
    chk("err2_htrans", 64'(htrans_a), 64'h0);
    tick();
    idle_in();
    settle();
    chk("err_err_cnt", 64'(ec_a), 64'h1);
    chk("err_xfer_cnt", 64'(xc_a), 64'h5);
    chk("sat_xfer_cnt_b", 64'(xc_b), 64'h3);
    chk("err_rvalid_after", 64'(rvalid_a), 64'h0);
    tick();

    // Illegal byte enables: local error on a, full-width transfer on b
    set_req(0, 4'b0110, 32'h501, 32'h0);
    settle();
    chk("lbe_gnt", 64'(gnt_a), 64'h1);
    chk("lbe_htrans", 64'(htrans_a), 64'h0);
    chk("lbe_b_htrans", 64'(htrans_b), 64'h2);
    chk("lbe_b_hsize", 64'(hsize_b), 64'h2);
    chk("lbe_b_haddr", 64'(haddr_b), 64'h500);
    tick();
    idle_in();
    settle();
    chk("lbe_rvalid", 64'(rvalid_a), 64'h1);
    chk("lbe_err", 64'(err_a), 64'h1);
    chk("lbe_b_rvalid", 64'(rvalid_b), 64'h1);
    chk("lbe_b_err", 64'(err_b), 64'h0);
    tick();
    settle();
    chk("lbe_xfer_cnt", 64'(xc_a), 64'h5);
    chk("lbe_err_cnt", 64'(ec_a), 64'h2);
    tick();

    // pending_dbus_xfer_i blocks grants but not the in-flight data phase
    set_req(0, 4'hF, 32'h700, 32'h0);
    tick();
    set_req(0, 4'hF, 32'h704, 32'h0); pend = 1; hrdata = 32'h1234_5678;
    settle();
    chk("pend_gnt", 64'(gnt_a), 64'h0);
    chk("pend_rvalid", 64'(rvalid_a), 64'h1);
    chk("pend_rdata", 64'(rdata_a), 64'h1234_5678);
    tick();
    idle_in();
    tick();

    // Reset in the middle of a data phase
    set_req(0, 4'hF, 32'h800, 32'h0);
    tick();
    idle_in(); rst = 1;
    settle();
    chk("mrst_rvalid", 64'(rvalid_a), 64'h0);
    chk("mrst_gnt", 64'(gnt_a), 64'h0);
    tick();
    rst = 0;
    settle();
    chk("mrst_rvalid_after", 64'(rvalid_a), 64'h0);
    chk("mrst_xfer_cnt", 64'(xc_a), 64'h0);
    chk("mrst_hwdata", 64'(hwdata_a), 64'h0);
    tick();

    // Sweep every byte-enable pattern back to back, with periodic wait states
    for (int i = 0; i < 16; i++) begin
      if (i % 3 == 2) begin
        set_req(0, 4'hF, 32'h0, 32'h0); hready = 0; hrdata = 32'h0BAD_0000 | 32'(i);
        tick();
      end
      set_req(i[0], 4'(i), 32'h900 + 32'(i * 16) + 32'h3, 32'hA500_0000 | 32'(i));
      hready = 1; pend = (i == 5); priv = i[1];
      hrdata = 32'h5A5A_0000 | 32'(i);
      tick();
    end
    idle_in();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
